// File: rtl/wrch_upsize_fifo.sv
// Write-channel upsizing FIFO: packs 32-bit write beats with strobes into LANES-wide entries.
// Optional sticky overflow/underflow flags are enabled by defining WRCH_UPSIZE_ERR_EN.
module wrch_upsize_fifo #(
  parameter  int WR_DATA_BIT = 32,
  parameter  int LANES       = 2,
  parameter  int DEPTH       = 16,
  localparam int LW          = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int AW          = $clog2(DEPTH),
  localparam int RD_DATA_BIT = LANES * WR_DATA_BIT,
  localparam int SB          = LANES * 4
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   wr_en,
  input  logic                   wr_first,
  input  logic [LW-1:0]          wr_lane_init,
  input  logic                   wr_last,
  input  logic [WR_DATA_BIT-1:0] wr_data,
  input  logic [3:0]             wr_strb,
  output logic                   wr_full,
  input  logic                   rd_en,
  output logic [RD_DATA_BIT-1:0] rd_data,
  output logic [SB-1:0]          rd_strb,
  output logic                   rd_last,
  output logic                   rd_valid,
  output logic                   rd_empty,
`ifdef WRCH_UPSIZE_ERR_EN
  input  logic                   err_clr,
  output logic                   ovfl_err,
  output logic                   udfl_err,
`endif
  output logic [AW:0]            count
);

  logic [RD_DATA_BIT-1:0] mem_data [DEPTH];
  logic [SB-1:0]          mem_strb [DEPTH];
  logic                   mem_last [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] lane_ptr, lane;
  logic [SB-1:0] open_strb, strb_next;
  logic          accept, close, pop;

  assign wr_full  = (count == (AW+1)'(DEPTH));
  assign rd_empty = (count == '0);
  assign accept   = wr_en && !wr_full;
  assign pop      = rd_en && !rd_empty;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lane      = '0;
    strb_next = '0;
    if (LANES > 1) lane = wr_first ? wr_lane_init : lane_ptr;
    // wr_first discards any partially built entry, so its strobes are not carried over.
    strb_next = (wr_first ? '0 : open_strb) | (SB'(wr_strb) << {lane, 2'b00});
  end

  assign close = accept && (lane == LW'(LANES - 1) || wr_last);

  // NOTE: storage is not reset; validity is tracked solely by count and the pointers.
  always_ff @(posedge ACLK) begin
    if (accept) mem_data[wr_ptr][lane*WR_DATA_BIT +: WR_DATA_BIT] <= wr_data;
    if (close) begin
      mem_strb[wr_ptr] <= strb_next;
      mem_last[wr_ptr] <= wr_last;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lane_ptr  <= '0;
      count     <= '0;
      open_strb <= '0;
      rd_data   <= '0;
      rd_strb   <= '0;
      rd_last   <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      if (accept) begin
        if (close) begin
          wr_ptr    <= wr_ptr + 1'b1;
          open_strb <= '0;
          lane_ptr  <= '0;
        end else begin
          open_strb <= strb_next;
          lane_ptr  <= lane + 1'b1;
        end
      end
      case ({close, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rd_valid <= pop;
      if (pop) begin
        rd_data <= mem_data[rd_ptr];
        rd_strb <= mem_strb[rd_ptr];
        rd_last <= mem_last[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef WRCH_UPSIZE_ERR_EN
  // Sticky error flags; a clear pulse wins over a same-cycle set.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ovfl_err <= 1'b0;
      udfl_err <= 1'b0;
    end else if (err_clr) begin
      ovfl_err <= 1'b0;
      udfl_err <= 1'b0;
    end else begin
      if (wr_en && wr_full)  ovfl_err <= 1'b1;
      if (rd_en && rd_empty) udfl_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wrch_upsize_fifo.sv
// Directed bench for wrch_upsize_fifo (LANES=2, DEPTH=16) with a scoreboard of expected entries.
module tb_wrch_upsize_fifo;
  localparam int LANES = 2;
  localparam int DEPTH = 16;
  localparam int LW    = 1;
  localparam int AW    = 4;
  localparam int RD    = LANES * 32;
  localparam int SB    = LANES * 4;

  typedef struct {
    logic [RD-1:0] data;
    logic [RD-1:0] mask;
    logic [SB-1:0] strb;
    logic          last;
  } ent_t;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          wr_en, wr_first, wr_last, rd_en;
  logic [LW-1:0] wr_lane_init;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic          wr_full, rd_last, rd_valid, rd_empty;
  logic [RD-1:0] rd_data;
  logic [SB-1:0] rd_strb;
  logic [AW:0]   count;
  logic          err_clr;
`ifdef WRCH_UPSIZE_ERR_EN
  logic          ovfl_err, udfl_err;
  bit            m_ovfl, m_udfl;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ent_t          sb[$];
  int            m_lane;
  logic [RD-1:0] o_data, o_mask;
  logic [SB-1:0] o_strb;
  logic [RD-1:0] m_rd_data;
  logic [SB-1:0] m_rd_strb;
  logic          m_rd_last;
  bit            m_hold_known;

  always #5 ACLK = ~ACLK;

  wrch_upsize_fifo #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .wr_en(wr_en), .wr_first(wr_first), .wr_lane_init(wr_lane_init),
    .wr_last(wr_last), .wr_data(wr_data), .wr_strb(wr_strb), .wr_full(wr_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_strb(rd_strb), .rd_last(rd_last),
    .rd_valid(rd_valid), .rd_empty(rd_empty),
`ifdef WRCH_UPSIZE_ERR_EN
    .err_clr(err_clr), .ovfl_err(ovfl_err), .udfl_err(udfl_err),
`endif
    .count(count)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_lane = 0;
    o_data = '0; o_mask = '0; o_strb = '0;
    m_rd_data = '0; m_rd_strb = '0; m_rd_last = 1'b0; m_hold_known = 1'b1;
`ifdef WRCH_UPSIZE_ERR_EN
    m_ovfl = 1'b0; m_udfl = 1'b0;
`endif
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, 128'(count), 128'(sb.size()));
    check({tag, ".full"},  128'(wr_full), 128'(sb.size() == DEPTH));
    check({tag, ".empty"}, 128'(rd_empty), 128'(sb.size() == 0));
`ifdef WRCH_UPSIZE_ERR_EN
    check({tag, ".ovfl"}, 128'(ovfl_err), 128'(m_ovfl));
    check({tag, ".udfl"}, 128'(udfl_err), 128'(m_udfl));
`endif
  endtask

  // One clock: optional beat and optional pop, with the model advanced alongside.
  task automatic tick(input string tag, input bit we, input bit fi, input int li, input bit la,
                      input logic [31:0] d, input logic [3:0] s, input bit re);
    int   n;
    bit   full_pre, pop, acc;
    int   lane;
    ent_t e;
    n        = sb.size();
    full_pre = (n == DEPTH);
    pop      = re && (n != 0);
    acc      = we && !full_pre;
    wr_en = we; wr_first = fi; wr_lane_init = LW'(li); wr_last = la;
    wr_data = d; wr_strb = s; rd_en = re;
    @(posedge ACLK); #1;
    wr_en = 1'b0; rd_en = 1'b0; wr_first = 1'b0; wr_last = 1'b0;
`ifdef WRCH_UPSIZE_ERR_EN
    if (err_clr) begin
      m_ovfl = 1'b0; m_udfl = 1'b0;
    end else begin
      if (we && full_pre) m_ovfl = 1'b1;
      if (re && n == 0)   m_udfl = 1'b1;
    end
`endif
    check({tag, ".valid"}, 128'(rd_valid), 128'(pop));
    if (pop) begin
      e = sb.pop_front();
      check({tag, ".data"}, 128'(rd_data & e.mask), 128'(e.data & e.mask));
      check({tag, ".strb"}, 128'(rd_strb), 128'(e.strb));
      check({tag, ".last"}, 128'(rd_last), 128'(e.last));
      m_rd_data = e.data; m_rd_strb = e.strb; m_rd_last = e.last;
      m_hold_known = (e.mask == '1);
    end else if (re) begin
      if (m_hold_known) check({tag, ".hold_data"}, 128'(rd_data), 128'(m_rd_data));
      check({tag, ".hold_strb"}, 128'(rd_strb), 128'(m_rd_strb));
      check({tag, ".hold_last"}, 128'(rd_last), 128'(m_rd_last));
    end
    if (acc) begin
      lane = fi ? li : m_lane;
      if (fi) begin
        o_mask = '0; o_strb = '0;
      end
      o_data[lane*32 +: 32] = d;
      o_mask[lane*32 +: 32] = '1;
      o_strb[lane*4 +: 4]  = o_strb[lane*4 +: 4] | s;
      if (lane == LANES - 1 || la) begin
        e.data = o_data; e.mask = o_mask; e.strb = o_strb; e.last = la;
        sb.push_back(e);
        o_mask = '0; o_strb = '0; m_lane = 0;
      end else begin
        m_lane = lane + 1;
      end
    end
    check_status(tag);
  endtask

  task automatic fill_full_entries(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      tick("fill_lo", 1, 1, 0, 0, base + 32'(2 * i), 4'hF, 0);
      tick("fill_hi", 1, 0, 0, 1, base + 32'(2 * i + 1), 4'hF, 0);
    end
  endtask

  initial begin
    ARESETN = 1'b0; err_clr = 1'b0;
    wr_en = 0; wr_first = 0; wr_last = 0; rd_en = 0;
    wr_lane_init = '0; wr_data = '0; wr_strb = '0;
    model_reset();
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;

    // Reset state.
    check("rst.valid", 128'(rd_valid), 128'(0));
    check("rst.data",  128'(rd_data), 128'(0));
    check("rst.strb",  128'(rd_strb), 128'(0));
    check("rst.last",  128'(rd_last), 128'(0));
    check_status("rst");

    // Two aligned beats forming one complete entry.
    tick("b0", 1, 1, 0, 0, 32'h1111_1111, 4'hF, 0);
    tick("b1", 1, 0, 0, 1, 32'h2222_2222, 4'hF, 0);
    tick("pop0", 0, 0, 0, 0, 32'h0, 4'h0, 1);
    check("pop0.exact", 128'(rd_data), 128'(64'h2222_2222_1111_1111));

    // Unaligned single-beat entry in lane 1.
    tick("ua", 1, 1, 1, 1, 32'hAABB_CCDD, 4'h3, 0);
    tick("pop_ua", 0, 0, 0, 0, 32'h0, 4'h0, 1);
    check("pop_ua.hi", 128'(rd_data[63:32]), 128'(32'hAABB_CCDD));

    // Fill to DEPTH, offer a dropped beat, drain half.
    fill_full_entries(DEPTH, 32'h1000_0000);
    tick("drop", 1, 1, 0, 1, 32'hDEAD_DEAD, 4'hF, 0);
    for (int i = 0; i < DEPTH / 2; i++) tick("drain_a", 0, 0, 0, 0, 32'h0, 4'h0, 1);

    // Close and pop in the same cycle at count 8.
    tick("cp_lo", 1, 1, 0, 0, 32'h5555_0000, 4'hF, 0);
    tick("cp_hi", 1, 0, 0, 1, 32'h5555_0001, 4'hF, 1);
    check("cp.count8", 128'(count), 128'(DEPTH / 2));

    // Drain the rest, then pop while empty (ignored, outputs held).
    for (int i = 0; i < DEPTH / 2; i++) tick("drain_b", 0, 0, 0, 0, 32'h0, 4'h0, 1);
    tick("empty_rd", 0, 0, 0, 0, 32'h0, 4'h0, 1);

    // Pointers have wrapped: a fresh entry still comes out intact.
    tick("wrap_lo", 1, 1, 0, 0, 32'h7777_0000, 4'hC, 0);
    tick("wrap_hi", 1, 0, 0, 0, 32'h7777_0001, 4'h1, 0);
    tick("wrap_pop", 0, 0, 0, 0, 32'h0, 4'h0, 1);

    // wr_first abandons a partial entry.
    tick("part", 1, 1, 0, 0, 32'hDEAD_BEEF, 4'hF, 0);
    tick("restart", 1, 1, 0, 1, 32'hCAFE_F00D, 4'h1, 0);
    tick("pop_rs", 0, 0, 0, 0, 32'h0, 4'h0, 1);
    check("pop_rs.strb", 128'(rd_strb), 128'(8'h01));

    // Reset mid-burst: state clears without waiting for a clock edge.
    tick("mr_e0", 1, 1, 0, 1, 32'h0BAD_0000, 4'hF, 0);
    tick("mr_e1", 1, 1, 0, 1, 32'h0BAD_0001, 4'hF, 1);
    tick("mr_open", 1, 1, 0, 0, 32'h0BAD_0002, 4'hF, 0);
    #2 ARESETN = 1'b0;
    #1;
    model_reset();
    check("mr.count", 128'(count), 128'(0));
    check("mr.empty", 128'(rd_empty), 128'(1));
    check("mr.valid", 128'(rd_valid), 128'(0));
    @(posedge ACLK); #1 ARESETN = 1'b1;
    tick("post_rst", 1, 1, 0, 1, 32'h1234_5678, 4'hF, 0);
    tick("post_pop", 0, 0, 0, 0, 32'h0, 4'h0, 1);

`ifdef WRCH_UPSIZE_ERR_EN
    tick("udfl_set", 0, 0, 0, 0, 32'h0, 4'h0, 1);
    tick("udfl_stay", 0, 0, 0, 0, 32'h0, 4'h0, 0);
    err_clr = 1'b1;
    tick("clr_prio", 0, 0, 0, 0, 32'h0, 4'h0, 1);
    err_clr = 1'b0;
    check("clr_prio.udfl", 128'(udfl_err), 128'(0));
    fill_full_entries(DEPTH, 32'h2000_0000);
    tick("ovfl_set", 1, 1, 0, 1, 32'hFFFF_FFFF, 4'hF, 0);
    check("ovfl.flag", 128'(ovfl_err), 128'(1));
    err_clr = 1'b1;
    tick("ovfl_clr", 0, 0, 0, 0, 32'h0, 4'h0, 0);
    err_clr = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
